// File: rtl/traffic_ctrl.sv
// traffic_ctrl: fourteen-phase intersection sequencer driven by a one-second
// prescaler. Each phase counts down whole seconds on `remain` and hands over
// to the next phase code when its last second expires.
// Optional night mode is compiled in with the macro NIGHT_MODE_EN; without it
// the `night` input is accepted but has no effect.
module traffic_ctrl #(
    parameter int TICK_CNT    = 50_000_000,
    parameter int GREEN_TIME  = 10,
    parameter int FLASH_TIME  = 3,
    parameter int YELLOW_TIME = 3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       pause,
    input  logic       night,
    output logic [3:0] state,
    output logic [5:0] remain,
    output logic       sec_tick
);

    // Prescaler width; a one-cycle tick period still needs a one-bit register.
    localparam int PW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CNT - 1);

    // Durations outside 1..63 are saturated so a zero never stalls a phase.
    function automatic logic [5:0] clamp_dur(input int t);
        if (t < 1) begin
            return 6'd1;
        end else if (t > 63) begin
            return 6'd63;
        end else begin
            return 6'(t);
        end
    endfunction

    localparam logic [5:0] GREEN_DUR  = clamp_dur(GREEN_TIME);
    localparam logic [5:0] FLASH_DUR  = clamp_dur(FLASH_TIME);
    localparam logic [5:0] YELLOW_DUR = clamp_dur(YELLOW_TIME);

    localparam logic [3:0] PHASE_FIRST  = 4'd0;
    localparam logic [3:0] PHASE_LAST   = 4'd13;
    localparam logic [3:0] PHASE_NS_YEL = 4'd6;
    localparam logic [3:0] PHASE_EW_LFT = 4'd7;

    logic [PW-1:0]     presc_reg, presc_next;
    logic [3:0]        phase_reg, phase_next;
    logic [5:0]        remain_reg, remain_next;
    logic              night_hold_reg, night_hold_next;
    logic [3:0]        phase_succ;
    logic [15:0][5:0]  dur_table;
    logic              night_req;
    logic              run;
    logic              tick;

    // Per-code duration lookup. Codes 14/15 are never loaded through this
    // table but are given the green value for completeness.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_dur
            if (gi == 6 || gi == 13) begin : g_yellow
                assign dur_table[gi] = YELLOW_DUR;
            end else if (gi == 1 || gi == 3 || gi == 5 ||
                         gi == 8 || gi == 10 || gi == 12) begin : g_flash
                assign dur_table[gi] = FLASH_DUR;
            end else begin : g_green
                assign dur_table[gi] = GREEN_DUR;
            end
        end
    endgenerate

`ifdef NIGHT_MODE_EN
    assign night_req = night;
`else
    // Port kept for pin compatibility; the request is deliberately dropped.
    logic night_unused;
    assign night_unused = night;
    assign night_req    = 1'b0;
`endif

    // A night request keeps the prescaler running even when pause is held.
    assign run        = !pause || night_req;
    assign tick       = run && (presc_reg == PRESC_LAST);
    assign phase_succ = (phase_reg == PHASE_LAST) ? PHASE_FIRST : phase_reg + 4'd1;

    // State register: prescaler, phase, countdown and night-hold flag.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            presc_reg      <= '0;
            phase_reg      <= PHASE_FIRST;
            remain_reg     <= GREEN_DUR;
            night_hold_reg <= 1'b0;
        end else begin
            presc_reg      <= presc_next;
            phase_reg      <= phase_next;
            remain_reg     <= remain_next;
            night_hold_reg <= night_hold_next;
        end
    end

    // Next-state logic: advance the prescaler, then act on each second boundary.
    always_comb begin
        presc_next      = presc_reg;
        phase_next      = phase_reg;
        remain_next     = remain_reg;
        night_hold_next = night_hold_reg;

        if (run) begin
            presc_next = (presc_reg == PRESC_LAST) ? '0 : presc_reg + 1'b1;
        end

        if (phase_reg > PHASE_LAST) begin
            // Illegal code (e.g. after an upset): recover immediately.
            phase_next      = PHASE_FIRST;
            remain_next     = GREEN_DUR;
            night_hold_next = 1'b0;
        end else if (tick) begin
            if (night_req) begin
                phase_next      = PHASE_NS_YEL;
                remain_next     = 6'd0;
                night_hold_next = 1'b1;
            end else if (night_hold_reg) begin
                phase_next      = PHASE_EW_LFT;
                remain_next     = GREEN_DUR;
                night_hold_next = 1'b0;
            end else if (remain_reg > 6'd1) begin
                remain_next = remain_reg - 6'd1;
            end else begin
                phase_next  = phase_succ;
                remain_next = dur_table[phase_succ];
            end
        end
    end

    // Outputs: phase and countdown straight from registers, tick from the prescaler.
    always_comb begin
        state    = phase_reg;
        remain   = remain_reg;
        sec_tick = tick;
    end

endmodule

// File: doc/traffic_ctrl.md
TRAFFIC_CTRL -- requirements
Module: traffic_ctrl

Interface
REQ-001 Parameter TICK_CNT, default 50_000_000: sys_clk cycles per one-second tick.
REQ-002 Parameter GREEN_TIME, default 10: seconds per steady-green phase.
REQ-003 Parameter FLASH_TIME, default 3: seconds per green-flash phase.
REQ-004 Parameter YELLOW_TIME, default 3: seconds per yellow-flash phase.
REQ-005 sys_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 sys_rst_n  input  1  reset, synchronous, active-low.
REQ-007 pause  input  1  high freezes prescaler, countdown and phase.
REQ-008 night  input  1  night-mode request (only effective with NIGHT_MODE_EN).
REQ-009 state  output  4  current phase code, registered, consumed by the LED driver.
REQ-010 remain  output  6  seconds left in current phase, registered.
REQ-011 sec_tick  output  1  one-cycle pulse at each one-second boundary.

Function
REQ-012 Phase codes SHALL be 0..13 in order: 0 NS-left, 1 NS-left-flash, 2 NS-straight, 3 NS-straight-flash, 4 NS-right, 5 NS-right-flash, 6 NS-yellow, 7 EW-left, 8 EW-left-flash, 9 EW-straight, 10 EW-straight-flash, 11 EW-right, 12 EW-right-flash, 13 EW-yellow; 13 wraps to 0.
REQ-013 Phase durations SHALL be: GREEN_TIME for 0,2,4,7,9,11; FLASH_TIME for 1,3,5,8,10,12; YELLOW_TIME for 6,13.
REQ-014 Prescaler SHALL count 0..TICK_CNT-1 and wrap; sec_tick SHALL be high exactly in the cycle the prescaler register equals TICK_CNT-1.
REQ-015 On sec_tick with remain > 1, remain SHALL decrement by 1 in the next cycle.
REQ-016 On sec_tick with remain == 1, state SHALL advance to the next code and remain SHALL load that code's duration, both in the next cycle.
REQ-017 Codes 14,15 SHALL never be output; if reached (e.g. upset), next cycle SHALL force state 0, remain GREEN_TIME.
REQ-018 Duration parameters SHALL be 1..63; a value of 0 SHALL be treated as 1.
REQ-019 While pause is high, prescaler, remain and state SHALL hold and sec_tick SHALL stay low; release resumes from the held prescaler value.
REQ-020 Phase is a Moore output: state and remain change only as in REQ-015..REQ-017 or REQ-025..REQ-026.

Reset
REQ-021 With sys_rst_n low at a rising edge: state=0, remain=GREEN_TIME, prescaler=0, sec_tick=0, night-hold flag=0.
REQ-022 Reset SHALL take priority over pause and night, including mid-phase and mid-tick.
REQ-023 First sec_tick after reset release SHALL occur TICK_CNT cycles after the first non-reset edge.

Configuration
REQ-024 Macro NIGHT_MODE_EN SHALL gate the night feature; without it the night port exists but is ignored and REQ-025..REQ-026 do not apply.
REQ-025 With NIGHT_MODE_EN: night high at a sec_tick SHALL force state=6, remain=0 next cycle and hold there while night is high; night overrides pause.
REQ-026 With NIGHT_MODE_EN: first sec_tick after night falls SHALL load state=7, remain=GREEN_TIME.

Verification
Bench parameters: TICK_CNT=4, GREEN_TIME=3, FLASH_TIME=2, YELLOW_TIME=2.
REQ-027 Reset then run 136 cycles -> state sequence 0..13 with remain 3,2,1 / 2,1 per phase, back to state 0, remain 3 at cycle 136.
REQ-028 sec_tick check -> pulses at cycles 3,7,11,...; exactly 1 cycle wide.
REQ-029 pause high for 20 cycles in state 2 with remain=2 -> state 2, remain 2, no sec_tick throughout; countdown resumes after release.
REQ-030 sys_rst_n low for one edge during state 9 -> next cycle state 0, remain 3, sec_tick 0.
REQ-031 NIGHT_MODE_EN defined, night high during state 3 -> state 6, remain 0 after next tick, held; night low -> state 7, remain 3 after next tick.
REQ-032 NIGHT_MODE_EN undefined, same stimulus -> sequence identical to REQ-027.
